// File: rtl/adma_desc_fetch_pkg.sv
// Shared definitions for the ADMA descriptor fetcher: FSM encoding, beat layout,
// descriptor command codes and the beat address helper.
package adma_desc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;

    localparam logic [1:0] BEAT_NEXT_CTL = 2'd0;
    localparam logic [1:0] BEAT_DCFC     = 2'd1;
    localparam logic [1:0] BEAT_SRC      = 2'd2;
    localparam logic [1:0] BEAT_DST      = 2'd3;

    localparam logic [3:0] DC_NULL = 4'h1;
    localparam logic [3:0] DC_FILL = 4'ha;

    // Each beat is 8 bytes; the sum wraps modulo 2^32.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] beat);
        return base + {27'd0, beat, 3'b000};
    endfunction

endpackage

// File: rtl/adma_desc_fetch.sv
// Fetches one 4-beat ADMA descriptor over a Wishbone burst, with retry accounting,
// bus-error handling and abort. Fields are staged and only committed on a clean burst.
module adma_desc_fetch
    import adma_desc_fetch_pkg::*;
#(
    parameter int RTY_MAX    = 8,
    parameter int DESC_BEATS = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] desc_addr_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        desc_valid_o,
    input  logic        desc_ack_i,
    output logic [31:0] desc_next_o,
    output logic [31:0] desc_ctl_o,
    output logic [31:0] desc_dcfc_o,
    output logic [31:0] desc_src_o,
    output logic [31:0] desc_dst_o,
    output logic        desc_last_o,
    output logic        err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic        wbm_cab_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic [31:0] wbm_dat64_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    localparam int               RTY_W     = $clog2(RTY_MAX + 2);
    localparam logic [1:0]       LAST_BEAT = 2'(DESC_BEATS - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RTY_MAX);

    fetch_state_e     state_q;
    logic [31:0]      base_q;
    logic [31:0]      adr_q;
    logic [1:0]       beat_q;
    logic [1:0]       beat_d;
    logic [RTY_W-1:0] rty_q;
    logic             cyc_q;
    logic             stb_q;
    logic             cab_q;
    logic [3:0]       sel_q;
    logic             busy_q;
    logic             valid_q;
    logic             err_q;
    logic [31:0]      stg_next_q;
    logic [31:0]      stg_ctl_q;
    logic [31:0]      stg_dcfc_q;
    logic [31:0]      stg_src_q;
    logic [31:0]      next_q;
    logic [31:0]      ctl_q;
    logic [31:0]      dcfc_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      start_base_d;

    assign beat_d       = beat_q + 2'd1;
    assign start_base_d = desc_addr_i & 32'hffff_fff8;

    // Fetch FSM: bus handshake, retry accounting and descriptor capture
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q    <= ST_IDLE;
            base_q     <= 32'h0;
            adr_q      <= 32'h0;
            beat_q     <= 2'd0;
            rty_q      <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            cab_q      <= 1'b0;
            sel_q      <= 4'h0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            stg_next_q <= 32'h0;
            stg_ctl_q  <= 32'h0;
            stg_dcfc_q <= 32'h0;
            stg_src_q  <= 32'h0;
            next_q     <= 32'h0;
            ctl_q      <= 32'h0;
            dcfc_q     <= 32'h0;
            src_q      <= 32'h0;
            dst_q      <= 32'h0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q  <= start_base_d;
                        adr_q   <= start_base_d;
                        beat_q  <= 2'd0;
                        rty_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cab_q   <= 1'b1;
                        sel_q   <= 4'hf;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (abort_i) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        cab_q   <= 1'b0;
                        sel_q   <= 4'h0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!stb_q) begin
                        // Retry gap: reissue the same address
                        stb_q <= 1'b1;
                    end else if (wbm_err_i) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        cab_q   <= 1'b0;
                        sel_q   <= 4'h0;
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else if (wbm_ack_i) begin
                        rty_q <= '0;
                        case (beat_q)
                            BEAT_NEXT_CTL: begin
                                stg_next_q <= wbm_dat64_i;
                                stg_ctl_q  <= wbm_dat_i;
                            end
                            BEAT_DCFC: stg_dcfc_q <= wbm_dat64_i;
                            BEAT_SRC:  stg_src_q  <= wbm_dat64_i;
                            default: begin
                                stg_src_q <= stg_src_q;
                            end
                        endcase
                        if (beat_q == LAST_BEAT) begin
                            next_q  <= stg_next_q;
                            ctl_q   <= stg_ctl_q;
                            dcfc_q  <= stg_dcfc_q;
                            src_q   <= stg_src_q;
                            dst_q   <= wbm_dat64_i;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            cab_q   <= 1'b0;
                            sel_q   <= 4'h0;
                            valid_q <= 1'b1;
                            state_q <= ST_VALID;
                        end else begin
                            beat_q <= beat_d;
                            adr_q  <= beat_addr(base_q, beat_d);
                        end
                    end else if (wbm_rty_i) begin
                        if (rty_q == RTY_LIMIT) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            cab_q   <= 1'b0;
                            sel_q   <= 4'h0;
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            rty_q <= rty_q + RTY_W'(1);
                            stb_q <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_VALID: begin
                    if (desc_ack_i || abort_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_VALID;
                    end
                end
                ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    cab_q   <= 1'b0;
                    sel_q   <= 4'h0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign desc_valid_o = valid_q;
    assign err_o        = err_q;
    assign desc_next_o  = next_q;
    assign desc_ctl_o   = ctl_q;
    assign desc_dcfc_o  = dcfc_q;
    assign desc_src_o   = src_q;
    assign desc_dst_o   = dst_q;
    assign desc_last_o  = (next_q == 32'h0);
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = stb_q;
    assign wbm_we_o     = 1'b0;
    assign wbm_cab_o    = cab_q;
    assign wbm_adr_o    = adr_q;
    assign wbm_sel_o    = sel_q;

endmodule

// File: tb/tb_adma_desc_fetch.sv
// Self-checking bench for adma_desc_fetch: directed vector table, hand-written
// abort/reset sequences and randomized fetches against a transaction-level model.
module tb_adma_desc_fetch;

    localparam int RTY_MAX = 8;
    localparam int NO_ERR  = 7;

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0][31:0] w;        // w[2b] low word, w[2b+1] high word of beat b
        logic [3:0][7:0]  rty;      // retries inserted before answering beat b
        logic [2:0]       err_beat; // beat answered with err+ack, NO_ERR for none
        logic             exp_err;
        logic [31:0]      exp_next;
        logic [31:0]      exp_ctl;
        logic [31:0]      exp_dcfc;
        logic [31:0]      exp_src;
        logic [31:0]      exp_dst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] desc_addr_i;
    logic        abort_i;
    logic        desc_ack_i;
    logic [31:0] wbm_dat_i;
    logic [31:0] wbm_dat64_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;
    logic        busy_o;
    logic        desc_valid_o;
    logic [31:0] desc_next_o;
    logic [31:0] desc_ctl_o;
    logic [31:0] desc_dcfc_o;
    logic [31:0] desc_src_o;
    logic [31:0] desc_dst_o;
    logic        desc_last_o;
    logic        err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_cab_o;
    logic [31:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;

    always #5 clk = ~clk;

    adma_desc_fetch #(.RTY_MAX(RTY_MAX), .DESC_BEATS(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .start_i      (start_i),
        .desc_addr_i  (desc_addr_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .desc_valid_o (desc_valid_o),
        .desc_ack_i   (desc_ack_i),
        .desc_next_o  (desc_next_o),
        .desc_ctl_o   (desc_ctl_o),
        .desc_dcfc_o  (desc_dcfc_o),
        .desc_src_o   (desc_src_o),
        .desc_dst_o   (desc_dst_o),
        .desc_last_o  (desc_last_o),
        .err_o        (err_o),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_we_o     (wbm_we_o),
        .wbm_cab_o    (wbm_cab_o),
        .wbm_adr_o    (wbm_adr_o),
        .wbm_sel_o    (wbm_sel_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_dat64_i  (wbm_dat64_i),
        .wbm_ack_i    (wbm_ack_i),
        .wbm_err_i    (wbm_err_i),
        .wbm_rty_i    (wbm_rty_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_lo [logic [31:0]];
    logic [31:0] mem_hi [logic [31:0]];

    // Model state: the last descriptor successfully delivered
    logic [31:0] cur_next, cur_ctl, cur_dcfc, cur_src, cur_dst;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][31:0] mk_w(input logic [31:0] h0, input logic [31:0] l0,
                                              input logic [31:0] h1, input logic [31:0] h2,
                                              input logic [31:0] h3);
        logic [7:0][31:0] w;
        w[0] = l0;           w[1] = h0;
        w[2] = 32'hbad0_0001; w[3] = h1;
        w[4] = 32'hbad0_0002; w[5] = h2;
        w[6] = 32'hbad0_0003; w[7] = h3;
        return w;
    endfunction

    // Outcome of a fetch from the rules: any err beat or retry overrun fails it
    function automatic void model_fill(inout vec_t v);
        bit fail = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (int'(v.rty[b]) > RTY_MAX || int'(v.err_beat) == b) fail = 1'b1;
        end
        v.exp_err = fail;
        if (fail) begin
            v.exp_next = cur_next; v.exp_ctl = cur_ctl; v.exp_dcfc = cur_dcfc;
            v.exp_src  = cur_src;  v.exp_dst = cur_dst;
        end else begin
            v.exp_next = v.w[1]; v.exp_ctl = v.w[0]; v.exp_dcfc = v.w[3];
            v.exp_src  = v.w[5]; v.exp_dst = v.w[7];
        end
    endfunction

    task automatic load_mem(input vec_t v);
        logic [31:0] base;
        base = v.addr & 32'hffff_fff8;
        for (int b = 0; b < 4; b++) begin
            mem_lo[base + 32'(8 * b)] = v.w[2 * b];
            mem_hi[base + 32'(8 * b)] = v.w[2 * b + 1];
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cyc"},   32'(wbm_cyc_o), 32'h0);
        check({tag, "_stb"},   32'(wbm_stb_o), 32'h0);
        check({tag, "_cab"},   32'(wbm_cab_o), 32'h0);
        check({tag, "_we"},    32'(wbm_we_o), 32'h0);
        check({tag, "_sel"},   32'(wbm_sel_o), 32'h0);
        check({tag, "_adr"},   wbm_adr_o, 32'h0);
        check({tag, "_busy"},  32'(busy_o), 32'h0);
        check({tag, "_valid"}, 32'(desc_valid_o), 32'h0);
        check({tag, "_err"},   32'(err_o), 32'h0);
        check({tag, "_next"},  desc_next_o, 32'h0);
        check({tag, "_ctl"},   desc_ctl_o, 32'h0);
        check({tag, "_dcfc"},  desc_dcfc_o, 32'h0);
        check({tag, "_src"},   desc_src_o, 32'h0);
        check({tag, "_dst"},   desc_dst_o, 32'h0);
    endtask

    task automatic check_fields(input string tag, input vec_t v);
        check({tag, "_next"}, desc_next_o, v.exp_next);
        check({tag, "_ctl"},  desc_ctl_o,  v.exp_ctl);
        check({tag, "_dcfc"}, desc_dcfc_o, v.exp_dcfc);
        check({tag, "_src"},  desc_src_o,  v.exp_src);
        check({tag, "_dst"},  desc_dst_o,  v.exp_dst);
        check({tag, "_last"}, 32'(desc_last_o), 32'(v.exp_next == 32'h0));
    endtask

    // Runs one fetch with a scripted Wishbone slave and checks the outcome
    task automatic run_fetch(input vec_t v, input string tag, input bit finish_abort);
        logic [31:0] base;
        logic [31:0] exp_adr [$];
        logic [31:0] got_adr [$];
        int exp_cyc, cyc_cnt, err_cnt, bad_ctl, beat, given, t_end, n_cmp_adr;
        bit seen_valid;
        base = v.addr & 32'hffff_fff8;
        exp_cyc = 0;
        for (int b = 0; b < 4; b++) begin
            int r = int'(v.rty[b]);
            if (r > RTY_MAX) begin
                for (int k = 0; k <= RTY_MAX; k++) exp_adr.push_back(base + 32'(8 * b));
                exp_cyc += 2 * RTY_MAX + 1;
                break;
            end
            for (int k = 0; k <= r; k++) exp_adr.push_back(base + 32'(8 * b));
            exp_cyc += 2 * r + 1;
            if (int'(v.err_beat) == b) break;
        end
        load_mem(v);
        cyc_cnt = 0; err_cnt = 0; bad_ctl = 0; beat = 0; given = 0; t_end = -1;
        seen_valid = 1'b0;
        desc_addr_i = v.addr;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int t = 0; t < 200; t++) begin
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
            if (desc_valid_o) begin seen_valid = 1'b1; t_end = t; break; end
            if (err_o) err_cnt++;
            if (!busy_o) begin t_end = t; break; end
            if (wbm_cyc_o) begin
                cyc_cnt++;
                if (!wbm_cab_o || wbm_sel_o != 4'hf || wbm_we_o) bad_ctl++;
            end
            if (wbm_cyc_o && wbm_stb_o) begin
                got_adr.push_back(wbm_adr_o);
                if (beat < 4 && given < int'(v.rty[beat])) begin
                    wbm_rty_i = 1'b1;
                    given++;
                end else begin
                    wbm_ack_i   = 1'b1;
                    wbm_err_i   = (beat < 4 && int'(v.err_beat) == beat);
                    wbm_dat_i   = mem_lo.exists(wbm_adr_o) ? mem_lo[wbm_adr_o] : 32'h0;
                    wbm_dat64_i = mem_hi.exists(wbm_adr_o) ? mem_hi[wbm_adr_o] : 32'h0;
                    beat++;
                    given = 0;
                end
            end
            @(negedge clk);
        end
        check({tag, "_timeout"}, 32'(t_end < 0), 32'h0);
        check({tag, "_done_cycle"}, 32'(t_end), 32'(exp_cyc + (v.exp_err ? 1 : 0)));
        check({tag, "_n_adr"}, 32'(got_adr.size()), 32'(exp_adr.size()));
        n_cmp_adr = (got_adr.size() < exp_adr.size()) ? got_adr.size() : exp_adr.size();
        for (int i = 0; i < n_cmp_adr; i++) check({tag, "_adr"}, got_adr[i], exp_adr[i]);
        check({tag, "_cyc_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
        check({tag, "_bus_ctl"}, 32'(bad_ctl), 32'h0);
        check({tag, "_err_pulses"}, 32'(err_cnt), 32'(v.exp_err));
        check({tag, "_valid_seen"}, 32'(seen_valid), 32'(!v.exp_err));
        if (seen_valid) begin
            int hold = $urandom_range(1, 3);
            bit held_ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                start_i = (h == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                desc_addr_i = $urandom;
                @(negedge clk);
                if (!desc_valid_o || wbm_cyc_o) held_ok = 1'b0;
            end
            start_i = 1'b0;
            check({tag, "_valid_hold"}, 32'(held_ok), 32'h1);
            check_fields(tag, v);
            if (finish_abort) abort_i = 1'b1;
            else desc_ack_i = 1'b1;
            @(negedge clk);
            abort_i = 1'b0;
            desc_ack_i = 1'b0;
            check({tag, "_valid_clr"}, 32'(desc_valid_o), 32'h0);
            check({tag, "_busy_clr"}, 32'(busy_o), 32'h0);
        end else begin
            check_fields(tag, v);
        end
        if (!v.exp_err) begin
            cur_next = v.exp_next; cur_ctl = v.exp_ctl; cur_dcfc = v.exp_dcfc;
            cur_src  = v.exp_src;  cur_dst = v.exp_dst;
        end
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; start_i = 1'b0; desc_addr_i = 32'h0; abort_i = 1'b0;
        desc_ack_i = 1'b0; wbm_dat_i = 32'h0; wbm_dat64_i = 32'h0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        cur_next = 32'h0; cur_ctl = 32'h0; cur_dcfc = 32'h0; cur_src = 32'h0; cur_dst = 32'h0;

        // Directed table
        vecs[0] = '0;
        vecs[0].addr = 32'h0;
        vecs[0].w = mk_w(32'h300, 32'h200, 32'h1, 32'h400, 32'h500);
        vecs[0].err_beat = 3'(NO_ERR);
        vecs[0].exp_next = 32'h300; vecs[0].exp_ctl = 32'h200; vecs[0].exp_dcfc = 32'h1;
        vecs[0].exp_src = 32'h400;  vecs[0].exp_dst = 32'h500;
        vecs[1] = vecs[0];
        vecs[1].rty[2] = 8'd2;
        vecs[2] = vecs[0];
        vecs[2].addr = 32'h40;
        vecs[2].w = mk_w(32'h111, 32'h222, 32'h333, 32'h444, 32'h555);
        vecs[2].err_beat = 3'd1;
        vecs[2].exp_err = 1'b1;
        vecs[3] = '0;
        vecs[3].addr = 32'h1000_0045;
        vecs[3].w = mk_w(32'h0, 32'h44, 32'h000a_000c, 32'h2000, 32'h100);
        vecs[3].err_beat = 3'(NO_ERR);
        vecs[3].exp_next = 32'h0;  vecs[3].exp_ctl = 32'h44; vecs[3].exp_dcfc = 32'h000a_000c;
        vecs[3].exp_src = 32'h2000; vecs[3].exp_dst = 32'h100;
        vecs[4] = '0;
        vecs[4].addr = 32'hffff_fff3;
        vecs[4].w = mk_w(32'ha1, 32'ha0, 32'hb1, 32'hc1, 32'hd1);
        vecs[4].rty[3] = 8'd1;
        vecs[4].err_beat = 3'(NO_ERR);
        vecs[4].exp_next = 32'ha1; vecs[4].exp_ctl = 32'ha0; vecs[4].exp_dcfc = 32'hb1;
        vecs[4].exp_src = 32'hc1;  vecs[4].exp_dst = 32'hd1;
        vecs[5] = vecs[4];
        vecs[5].addr = 32'h80;
        vecs[5].w = mk_w(32'h71, 32'h70, 32'h72, 32'h73, 32'h74);
        vecs[5].rty[3] = 8'd0;
        vecs[5].rty[0] = 8'(RTY_MAX + 1);
        vecs[5].exp_err = 1'b1;
        vecs[6] = vecs[4];
        vecs[6].addr = 32'h100;
        vecs[6].w = mk_w(32'h61, 32'h60, 32'h62, 32'h63, 32'h64);
        vecs[6].rty[3] = 8'd0;
        vecs[6].err_beat = 3'd3;
        vecs[6].exp_err = 1'b1;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_idle_busy", 32'(busy_o), 32'h0);
        check("abort_idle_cyc", 32'(wbm_cyc_o), 32'h0);

        for (int i = 0; i < 7; i++) run_fetch(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Abort in the second FETCH cycle
        load_mem(vecs[0]);
        desc_addr_i = 32'h0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("abort_cyc_up", 32'(wbm_cyc_o), 32'h1);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h200; wbm_dat64_i = 32'h300;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_cyc", 32'(wbm_cyc_o), 32'h0);
        check("abort_stb", 32'(wbm_stb_o), 32'h0);
        check("abort_busy", 32'(busy_o), 32'h0);
        check("abort_err", 32'(err_o), 32'h0);
        check("abort_valid", 32'(desc_valid_o), 32'h0);
        @(negedge clk);
        check("abort_err_late", 32'(err_o), 32'h0);
        check("abort_next_kept", desc_next_o, cur_next);

        // Reset in the middle of a burst
        desc_addr_i = 32'h0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = mem_lo[32'(8 * b)];
            wbm_dat64_i = mem_hi[32'(8 * b)];
            if (b == 2) rst_n = 1'b0;
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        check_zero("rst_mid");
        rst_n = 1'b1;
        cur_next = 32'h0; cur_ctl = 32'h0; cur_dcfc = 32'h0; cur_src = 32'h0; cur_dst = 32'h0;
        @(negedge clk);
        run_fetch(vecs[0], "post_rst", 1'b0);

        // Randomized fetches against the model
        for (int i = 0; i < 40; i++) begin
            v = '0;
            v.addr = ($urandom_range(0, 3) == 0) ? (32'hffff_ffe0 | 32'($urandom_range(0, 31))) : $urandom;
            for (int k = 0; k < 8; k++) v.w[k] = $urandom;
            if ($urandom_range(0, 3) == 0) v.w[1] = 32'h0;
            for (int b = 0; b < 4; b++) v.rty[b] = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) v.rty[$urandom_range(0, 3)] = 8'(RTY_MAX + 1);
            v.err_beat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'(NO_ERR);
            model_fill(v);
            run_fetch(v, $sformatf("rnd%0d", i), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
